// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt sequencer: state encodings,
// state width and the default clock-divider / reset-hold settings.
package cpu_ctrl_pkg;

   localparam int STATE_W            = 3;
   localparam int DEFAULT_DIV        = 4;
   localparam int DEFAULT_RESET_HOLD = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_HOLD = 3'd0,
      ST_IDLE = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } run_state_e;

endpackage

// File: rtl/proc_clk_phase_gen.sv
// Divides the board clock into processor-clock periods of DIV low cycles then
// DIV high cycles; emits proc_ce at each rise and flags the last high cycle.
module proc_clk_phase_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic processor_clk,
   output logic proc_ce,
   output logic phase_end_fall
);

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   logic [7:0] div_cnt;
   logic       phase_last;

   assign phase_last     = (div_cnt == DIV_LAST);
   // Combinational into the FSM so the state changes on the very edge that drops processor_clk.
   assign phase_end_fall = en && processor_clk && phase_last;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_cnt       <= '0;
         processor_clk <= 1'b0;
         proc_ce       <= 1'b0;
      end else begin
         proc_ce <= phase_last && !processor_clk;
         if (phase_last) begin
            div_cnt       <= '0;
            processor_clk <= !processor_clk;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer driving processor_clk and the CPU reset.
// Optional feature: define CYCLE_COUNTER_EN to enable the cycle_count register.
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int DIV        = DEFAULT_DIV,
   parameter int RESET_HOLD = DEFAULT_RESET_HOLD,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run_req,
   input  logic               step_req,
   input  logic               halt_in,
   output logic               processor_clk,
   output logic               proc_reset,
   output logic               proc_ce,
   output logic [STATE_W-1:0] state,
   output logic               halted,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD);

   run_state_e state_q, state_d;
   logic [7:0] hold_cnt;
   logic       phase_en;
   logic       phase_end_fall;

   assign phase_en = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign state    = state_q;

   proc_clk_phase_gen #(.DIV(DIV)) u_phase_gen (
      .clk            (clk),
      .reset          (reset),
      .en             (phase_en),
      .processor_clk  (processor_clk),
      .proc_ce        (proc_ce),
      .phase_end_fall (phase_end_fall)
   );

   // NOTE: state_d gets its default before the case so no path through this block infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD: if (hold_cnt == HOLD_LAST) state_d = ST_IDLE;
         ST_IDLE: begin
            if (halt_in)       state_d = ST_HALT;
            else if (run_req)  state_d = ST_RUN;
            else if (step_req) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (phase_end_fall) begin
               if (halt_in)       state_d = ST_HALT;
               else if (!run_req) state_d = ST_IDLE;
            end
         end
         ST_STEP: if (phase_end_fall) state_d = halt_in ? ST_HALT : ST_IDLE;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hold_cnt   <= '0;
         proc_reset <= 1'b1;
         halted     <= 1'b0;
      end else begin
         state_q    <= state_d;
         proc_reset <= (state_d == ST_HOLD);
         halted     <= (state_d == ST_HALT);
         if (state_q == ST_HOLD && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
      end
   end

`ifdef CYCLE_COUNTER_EN
   always_ff @(posedge clk) begin
      if (reset)        cycle_count <= '0;
      else if (proc_ce) cycle_count <= cycle_count + 1'b1;
   end
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: two instances (DIV=4 and DIV=1)
// compared every cycle against a period-position model, plus directed pins.
module tb_cpu_run_controller;
   import cpu_ctrl_pkg::*;

   localparam int A_DIV = 4, A_RH = 8, A_CW = 4;
   localparam int B_DIV = 1, B_RH = 1, B_CW = 16;
`ifdef CYCLE_COUNTER_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1, run_req = 1'b0, step_req = 1'b0, halt_in = 1'b0;

   logic             pc_a, pr_a, ce_a, hl_a, pc_b, pr_b, ce_b, hl_b;
   logic [2:0]       st_a, st_b;
   logic [A_CW-1:0]  cc_a;
   logic [B_CW-1:0]  cc_b;

   always #5 clk = ~clk;

   cpu_run_controller #(.DIV(A_DIV), .RESET_HOLD(A_RH), .CNT_W(A_CW)) u_dut_a (
      .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_in(halt_in),
      .processor_clk(pc_a), .proc_reset(pr_a), .proc_ce(ce_a), .state(st_a),
      .halted(hl_a), .cycle_count(cc_a));

   cpu_run_controller #(.DIV(B_DIV), .RESET_HOLD(B_RH), .CNT_W(B_CW)) u_dut_b (
      .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_in(halt_in),
      .processor_clk(pc_b), .proc_reset(pr_b), .proc_ce(ce_b), .state(st_b),
      .halted(hl_b), .cycle_count(cc_b));

   int total = 0, bad = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      total++;
      if (act !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: mode (0..4 as documented), position within the current period,
   // reset-hold cycles remaining, and processor rises counted so far.
   typedef struct {
      int st;
      int ph;
      int rem;
      int cnt;
   } mdl_t;

   function automatic bit m_clk(mdl_t m, int div);
      return (m.st == 2 || m.st == 3) && m.ph >= div;
   endfunction

   function automatic bit m_ce(mdl_t m, int div);
      return (m.st == 2 || m.st == 3) && m.ph == div;
   endfunction

   function automatic mdl_t m_step(mdl_t m, int div, int rh, int cw,
                                   bit rst, bit run, bit stp, bit hlt);
      mdl_t n = m;
      if (rst) begin
         n.st = 0; n.ph = 0; n.rem = rh; n.cnt = 0;
         return n;
      end
      if (CNT_ON && m_ce(m, div)) n.cnt = (m.cnt + 1) % (1 << cw);
      case (m.st)
         0: if (m.rem == 0) n.st = 1; else n.rem = m.rem - 1;
         1: begin
            n.ph = 0;
            if (hlt)      n.st = 4;
            else if (run) n.st = 2;
            else if (stp) n.st = 3;
         end
         2, 3: begin
            if (m.ph == 2 * div - 1) begin
               n.ph = 0;
               if (hlt)                   n.st = 4;
               else if (m.st == 3 || !run) n.st = 1;
            end else begin
               n.ph = m.ph + 1;
            end
         end
         default: n.st = 4;
      endcase
      return n;
   endfunction

   mdl_t ma, mb;

   always @(posedge clk) begin
      ma <= m_step(ma, A_DIV, A_RH, A_CW, reset, run_req, step_req, halt_in);
      mb <= m_step(mb, B_DIV, B_RH, B_CW, reset, run_req, step_req, halt_in);
   end

   task automatic cmp(input string tag, input mdl_t m, input int div, input logic [2:0] st,
                      input logic pc, input logic pr, input logic ce, input logic hl,
                      input logic [31:0] cc);
      check({tag, ".state"}, 32'(st), m.st);
      check({tag, ".processor_clk"}, 32'(pc), int'(m_clk(m, div)));
      check({tag, ".proc_reset"}, 32'(pr), int'(m.st == 0));
      check({tag, ".proc_ce"}, 32'(ce), int'(m_ce(m, div)));
      check({tag, ".halted"}, 32'(hl), int'(m.st == 4));
      check({tag, ".cycle_count"}, cc, m.cnt);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         cmp("A", ma, A_DIV, st_a, pc_a, pr_a, ce_a, hl_a, 32'(cc_a));
         cmp("B", mb, B_DIV, st_b, pc_b, pr_b, ce_b, hl_b, 32'(cc_b));
      end
   end

   initial begin
      int k, hi, rises;
      repeat (3) @(negedge clk);
      checking = 1'b1;
      check("rst_state", 32'(st_a), 0);
      check("rst_proc_reset", 32'(pr_a), 1);
      check("rst_pclk", 32'(pc_a), 0);
      check("rst_ce", 32'(ce_a), 0);
      check("rst_halted", 32'(hl_a), 0);
      check("rst_count", 32'(cc_a), 0);

      // Reset hold length.
      reset = 1'b0;
      hi = 0;
      do begin
         @(negedge clk);
         if (pr_a) hi++;
      end while (pr_a && hi < 50);
      check("hold_len", hi, 8);
      check("hold_to_idle", 32'(st_a), 1);
      check("idle_pclk", 32'(pc_a), 0);
      check("b_idle", 32'(st_b), 1);

      // Free run: entry latency, first rise, period, count and wrap.
      run_req = 1'b1;
      @(negedge clk);
      check("run_entry", 32'(st_a), 2);
      k = 0;
      while (!pc_a && k < 50) begin @(negedge clk); k++; end
      check("first_rise", k, 4);
      check("first_ce", 32'(ce_a), 1);
      rises = 1;
      k = 0;
      do begin @(negedge clk); k++; end while (!ce_a && k < 50);
      check("period", k, 8);
      rises++;
      k = 0;
      while (rises < 10 && k < 500) begin @(negedge clk); k++; if (ce_a) rises++; end
      @(negedge clk);
      check("count_10", 32'(cc_a), CNT_ON ? 10 : 0);
      k = 0;
      while (rises < 17 && k < 500) begin @(negedge clk); k++; if (ce_a) rises++; end
      @(negedge clk);
      check("count_wrap", 32'(cc_a), CNT_ON ? 1 : 0);

      // Drop run_req in a low phase: the period still completes.
      k = 0;
      while (!pc_a && k < 50) begin @(negedge clk); k++; end
      while (pc_a && k < 100) begin @(negedge clk); k++; end
      check("wait_fall", 32'(pc_a), 0);
      @(negedge clk);
      run_req = 1'b0;
      hi = 0; k = 0;
      while (st_a != 3'd1 && k < 50) begin @(negedge clk); k++; if (pc_a) hi++; end
      check("drop_high_len", hi, 4);
      check("drop_idle", 32'(st_a), 1);
      check("drop_pclk", 32'(pc_a), 0);

      // Single step with a second pulse dropped.
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      check("step_entry", 32'(st_a), 3);
      @(negedge clk);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      hi = 0; k = 0;
      while (st_a == 3'd3 && k < 50) begin if (pc_a) hi++; @(negedge clk); k++; end
      check("step_high_len", hi, 4);
      check("step_to_idle", 32'(st_a), 1);
      check("step_pclk", 32'(pc_a), 0);
      @(negedge clk);
      check("step_not_queued", 32'(st_a), 1);

      // Halt raised mid high phase: phase completes, then HALT is sticky.
      run_req = 1'b1;
      k = 0;
      while (!pc_a && k < 50) begin @(negedge clk); k++; end
      check("wait_rise", 32'(pc_a), 1);
      hi = 1;
      @(negedge clk);
      if (pc_a) hi++;
      halt_in = 1'b1;
      k = 0;
      while (st_a != 3'd4 && k < 50) begin @(negedge clk); k++; if (pc_a) hi++; end
      check("halt_high_len", hi, 4);
      check("halted", 32'(hl_a), 1);
      halt_in = 1'b0;
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      repeat (20) @(negedge clk);
      check("halt_sticky", 32'(st_a), 4);
      check("halt_pclk", 32'(pc_a), 0);

      // Reset in the middle of a high phase.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      k = 0;
      while (st_a != 3'd2 && k < 50) begin @(negedge clk); k++; end
      while (!pc_a && k < 100) begin @(negedge clk); k++; end
      check("wait_rise2", 32'(pc_a), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_pclk", 32'(pc_a), 0);
      check("mid_rst_proc_reset", 32'(pr_a), 1);
      check("mid_rst_count", 32'(cc_a), 0);
      check("mid_rst_state", 32'(st_a), 0);
      reset = 1'b0;
      run_req = 1'b0;

      // Randomised traffic against the model.
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         reset    = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) run_req = ~run_req;
         step_req = ($urandom_range(0, 7) == 0);
         halt_in  = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
